// File: rtl/hs_ram_bridge.sv
// hs_ram_bridge: arbitrates one work-RAM port between the CPU and the
// hiscore engine, with a drain cycle on handover and a one-entry write latch.
module hs_ram_bridge #(
  parameter logic [15:0] RAM_BASE = 16'h6000,
  parameter int          RAM_AW   = 12
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_din,
  input  logic              cpu_wr,
  output logic [7:0]        cpu_dout,
  input  logic [15:0]       hs_address,
  input  logic [7:0]        hs_data_in,
  input  logic              hs_write,
  input  logic              hs_access,
  output logic [7:0]        hs_data_out,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_we,
  input  logic [7:0]        ram_dout,
  output logic              hs_owned,
  output logic              cpu_conflict,
  output logic [7:0]        hs_wr_count
);

  typedef enum logic [1:0] {
    S_CPU,
    S_DRAIN,
    S_HS,
    S_RELEASE
  } state_t;

  localparam logic [16:0] WIN_LO = {1'b0, RAM_BASE};
  localparam logic [16:0] WIN_HI = WIN_LO + 17'(1 << RAM_AW);

  function automatic logic in_win(input logic [15:0] a);
    return ({1'b0, a} >= WIN_LO) && ({1'b0, a} < WIN_HI);
  endfunction

  state_t      state_q, state_d;
  logic        pend_vld_q, pend_vld_d;
  logic [15:0] pend_addr_q, pend_addr_d;
  logic [7:0]  pend_data_q, pend_data_d;
  logic        hs_rd_q, hs_rd_d;
  logic [7:0]  hs_dout_q, hs_dout_d;
  logic        cpu_side_q, cpu_side_d;
  logic        conflict_q, conflict_d;
  logic [7:0]  cnt_q, cnt_d;

  logic cpu_win;
  logic hs_win;
  logic pend_win;
  logic cpu_side;
  logic commit;
  logic hs_commit;

  assign cpu_win  = in_win(cpu_addr);
  assign hs_win   = in_win(hs_address);
  assign pend_win = in_win(pend_addr_q);
  assign cpu_side = (state_q == S_CPU) || (state_q == S_DRAIN);
  // A latched write drains on any owned cycle while access is still held.
  assign commit   = (state_q == S_HS) && pend_vld_q && hs_access;

  assign hs_owned     = (state_q == S_HS);
  assign cpu_conflict = conflict_q;
  assign hs_wr_count  = cnt_q;
  assign hs_data_out  = hs_dout_q;
  assign cpu_dout     = cpu_side_q ? ram_dout : 8'hFF;

  // RAM port mux: CPU by default, hiscore (latched or live) when owned.
  always_comb begin
    ram_addr  = cpu_addr[RAM_AW-1:0];
    ram_din   = cpu_din;
    ram_we    = cpu_wr && cpu_win;
    hs_commit = 1'b0;
    hs_rd_d   = 1'b0;
    unique case (state_q)
      S_CPU, S_DRAIN: begin
      end
      S_HS: begin
        if (commit) begin
          ram_addr  = pend_addr_q[RAM_AW-1:0];
          ram_din   = pend_data_q;
          ram_we    = pend_win;
          hs_commit = pend_win;
        end else begin
          ram_addr  = hs_address[RAM_AW-1:0];
          ram_din   = hs_data_in;
          ram_we    = hs_write && hs_win;
          hs_commit = hs_write && hs_win;
          hs_rd_d   = hs_win;
        end
      end
      S_RELEASE: begin
        ram_we = 1'b0;
      end
      default: begin
        ram_we = 1'b0;
      end
    endcase
  end

  // Ownership handover sequencing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_CPU: begin
        if (hs_access) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        state_d = hs_access ? S_HS : S_RELEASE;
      end
      S_HS: begin
        if (!hs_access) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        state_d = S_CPU;
      end
      default: begin
        state_d = S_CPU;
      end
    endcase
  end

  // Pending hiscore write latch; newest write wins.
  always_comb begin
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    if (commit) pend_vld_d = 1'b0;
    if (hs_write && hs_access &&
        (cpu_side || commit)) begin
      pend_vld_d  = 1'b1;
      pend_addr_d = hs_address;
      pend_data_d = hs_data_in;
    end
    if ((state_q == S_RELEASE) ||
        ((state_q == S_HS) && !hs_access))
      pend_vld_d = 1'b0;
  end

  // Read return paths, conflict flag and write counter.
  always_comb begin
    hs_dout_d  = hs_rd_q ? ram_dout : 8'h00;
    cpu_side_d = cpu_side;
    conflict_d = conflict_q;
    if (cpu_wr && !cpu_side) conflict_d = 1'b1;
    cnt_d = cnt_q;
    if (hs_commit && (cnt_q != 8'hFF))
      cnt_d = cnt_q + 8'd1;
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_CPU;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= 16'h0000;
      pend_data_q <= 8'h00;
      hs_rd_q     <= 1'b0;
      hs_dout_q   <= 8'h00;
      cpu_side_q  <= 1'b1;
      conflict_q  <= 1'b0;
      cnt_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      hs_rd_q     <= hs_rd_d;
      hs_dout_q   <= hs_dout_d;
      cpu_side_q  <= cpu_side_d;
      conflict_q  <= conflict_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: doc/hs_ram_bridge.md
HS_RAM_BRIDGE -- requirements
Module: hs_ram_bridge

Interface
- REQ-001 Parameter RAM_BASE, default 16'h6000: CPU/hiscore byte address of work-RAM word 0.
- REQ-002 Parameter RAM_AW, default 12: work-RAM address width; window = RAM_BASE .. RAM_BASE+2^RAM_AW-1.
- REQ-003 clk_sys  in  1: sole clock; all state changes on rising edge.
- REQ-004 reset_n  in  1: reset, asynchronous, active-low.
- REQ-005 cpu_addr  in  16: CPU address.
- REQ-006 cpu_din  in  8: CPU write data.
- REQ-007 cpu_wr  in  1: CPU write strobe, one cycle per write.
- REQ-008 cpu_dout  out  8: RAM read data to CPU.
- REQ-009 hs_address  in  16: hiscore engine address.
- REQ-010 hs_data_in  in  8: hiscore write data.
- REQ-011 hs_write  in  1: hiscore write strobe, one cycle per write.
- REQ-012 hs_access  in  1: hiscore engine requests RAM ownership; CPU is paused while high.
- REQ-013 hs_data_out  out  8: RAM read data to hiscore engine.
- REQ-014 ram_addr  out  RAM_AW: work-RAM address.
- REQ-015 ram_din  out  8: work-RAM write data.
- REQ-016 ram_we  out  1: work-RAM write enable.
- REQ-017 ram_dout  in  8: work-RAM read data, valid one cycle after ram_addr.
- REQ-018 hs_owned  out  1: high in S_HS only.
- REQ-019 cpu_conflict  out  1: sticky; CPU write attempted while hiscore owned RAM.
- REQ-020 hs_wr_count  out  8: saturating count of committed hiscore writes.

Function
- REQ-021 FSM states: S_CPU, S_DRAIN, S_HS, S_RELEASE.
- REQ-022 S_CPU: ram_addr = cpu_addr[RAM_AW-1:0]; ram_din = cpu_din; ram_we = cpu_wr and cpu_addr in window, combinational.
- REQ-023 S_CPU with hs_access=1 -> S_DRAIN next cycle.
- REQ-024 S_DRAIN lasts exactly one cycle; CPU mux stays active, so an in-flight CPU write completes; then S_HS if hs_access=1, else S_RELEASE.
- REQ-025 hs_write arriving in S_CPU or S_DRAIN (hs_access=1) is captured into a one-entry pending latch (address, data).
- REQ-026 A second hs_write while the latch is full overwrites it; only the latest pending write commits.
- REQ-027 First S_HS cycle with latch full: RAM drives latched address/data, ram_we=1 if in window; latch clears; a live hs_write that same cycle is latched and commits next cycle.
- REQ-028 Otherwise in S_HS: ram_addr = hs_address[RAM_AW-1:0]; ram_din = hs_data_in; ram_we = hs_write and hs_address in window.
- REQ-029 hs_data_out registered: hs_address in S_HS at cycle N -> ram_dout at N+1 -> hs_data_out valid at N+2; out-of-window address yields 8'h00 at N+2.
- REQ-030 cpu_dout = ram_dout when the previous cycle's state was S_CPU/S_DRAIN; else 8'hFF.
- REQ-031 CPU write in S_HS or S_RELEASE: not performed; cpu_conflict set to 1.
- REQ-032 S_HS with hs_access=0 -> S_RELEASE; pending latch discarded; S_RELEASE lasts one cycle, ram_we=0, then S_CPU.
- REQ-033 hs_access rising while in S_RELEASE: S_CPU for at least one cycle, then S_DRAIN.
- REQ-034 hs_wr_count increments by 1 per committed in-window hiscore write; holds at 8'hFF.
- REQ-035 Out-of-window writes from either side never assert ram_we and never count.

Reset
- REQ-036 reset_n=0: state S_CPU; latch empty; hs_data_out=8'h00; hs_owned=0; cpu_conflict=0; hs_wr_count=0.
- REQ-037 reset_n=0 mid-S_HS: same values immediately; pending write discarded, no ram_we after reset asserts.
- REQ-038 cpu_dout, ram_addr, ram_din, ram_we follow S_CPU muxing during and after reset.

Verification
- REQ-039 CPU writes 8'h5A to 16'h6010, reads back -> ram_we one cycle, ram_addr=12'h010, cpu_dout=8'h5A one cycle after read address.
- REQ-040 hs_access rises at cycle 0 -> S_DRAIN at 1, hs_owned=1 at 2; hs_address=16'h6010 at 2 -> hs_data_out=8'h5A at 4.
- REQ-041 hs_write 16'h6020/8'hA5 during S_DRAIN -> ram_we at first S_HS cycle with ram_addr=12'h020, ram_din=8'hA5; hs_wr_count=1.
- REQ-042 CPU write during S_HS -> no ram_we from CPU, cpu_conflict=1 held until reset_n=0.
- REQ-043 hs_write to 16'h7000 -> ram_we=0, count unchanged; hs_data_out=8'h00 two cycles after read of 16'h7000.
- REQ-044 256 in-window hiscore writes -> hs_wr_count=8'hFF; reset_n pulse mid-S_HS -> all REQ-036 values, state S_CPU.
